aead_bus_sequencer: RTL
=======================

# aead_bus_sequencer

Upstream bus master for the ChaCha20-Poly1305 register block (`chacha20_poly1305_bus`).
- Accepts one AEAD job: key, nonce, then a stream of 512-bit data blocks.
- Translates the job into the block's register protocol: key/nonce writes, init, per-block data write + next, status polling, result reads, done, tag read.
- Returns processed blocks and the final tag on valid/ready streams, so the rest of the design never touches register addresses.

## Interface
Parameters:
- POLL_LIMIT, 64: maximum status polls per wait before the job aborts with error.
- ADDR_CTRL 8'h08, ADDR_STATUS 8'h09, ADDR_KEY 8'h10, ADDR_NONCE 8'h20, ADDR_DATA 8'h30, ADDR_RESULT 8'h40, ADDR_TAG 8'h50: register map.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- job_valid / job_ready  in / out  1  job handshake; job_ready=1 only in IDLE.
- job_key  in  256  key, zero-extended to 512 on the bus.
- job_nonce  in  96  nonce, zero-extended to 512.
- blk_valid / blk_ready  in / out  1  input block handshake.
- blk_data  in  512  plaintext/ciphertext block.
- blk_last  in  1  marks the final block of the job.
- out_valid / out_ready  out / in  1  result block handshake.
- out_data  out  512  result word read from ADDR_RESULT.
- out_last  out  1  copy of the accepted blk_last.
- tag_valid / tag_ready  out / in  1  tag handshake, one per job.
- tag  out  128  ADDR_TAG read_data[127:0].
- tag_err  out  1  qualifies tag_valid; 1 means the job aborted on timeout and tag=0.
- cs, we  out  1  bus strobes.
- address  out  8  register address.
- write_data  out  512  bus write value.
- read_data  in  512  bus read value, valid the cycle after a read strobe.

## Operation
- Control word: init=512'h1, next=512'h2, done=512'h4.
- Status bits: read_data[0] ready, read_data[1] result valid.
- Each bus access is exactly one cycle with cs=1; cs=0 in every other state.
- Polls: strobe a read of ADDR_STATUS, sample on the next cycle, re-strobe on the cycle after that if the bit is clear.
- FSM:
  - IDLE: job handshake captures key/nonce → WR_KEY.
  - WR_KEY → WR_NONCE → WR_INIT (one write each) → POLL_RDY (wait status[0]) → WAIT_BLK.
  - WAIT_BLK: blk handshake captures data and last → WR_DATA → WR_NEXT (ctrl=next) → POLL_VAL (wait status[1]) → RD_RES.
  - RD_RES: read ADDR_RESULT → OUT (hold until out_ready).
  - OUT: then WAIT_BLK if last=0, else WR_DONE (ctrl=done).
  - WR_DONE → POLL_RDY2 (wait status[0]) → RD_TAG → TAG (hold until tag_ready) → IDLE.
- Poll counter clears on entry to each POLL state.
- Timeout: POLL_LIMIT unsuccessful samples → TAG with tag_err=1, tag=0. Remaining blk_* of that job are not consumed by this block.
- Handshake outputs are state-decoded (Moore). No combinational path from the ready inputs to any bus output.
- out_data, tag, and captured key/nonce/block are registers that are stable while the corresponding valid is held.

## Timing
- Reset values:
  - All valids/readies 0 except job_ready=1 in IDLE.
  - cs=0, we=0, address=0, write_data=0.
  - out_data=0, out_last=0, tag=0, tag_err=0.
  - State IDLE, counters 0.
- Job accept at edge T:
  - Key write at T+1, nonce at T+2, init at T+3, first status read at T+4, sampled at T+5.
  - With status ready on first poll, blk_ready rises at T+6.
- Block accept at edge B:
  - Data write at B+1, next at B+2, status read at B+3, sample at B+4, result read at B+5.
  - out_valid at B+7 at the earliest.
- Each failed poll adds 2 cycles.
- out_ready/tag_ready low: outputs and state hold indefinitely; no bus activity.
- Reset asserted mid-job: immediate return to IDLE, bus strobes drop asynchronously, no partial writes completed.

## Structure
- Package aead_bus_pkg: register address constants, control words, status bit indices, FSM state enum.
- Sub-module poll_counter: clear/increment, terminal flag at POLL_LIMIT.
- Everything else lives in the single top module.

## Test plan
- Reset held, then released: all outputs at reset values, job_ready=1, cs=0 throughout reset.
- Job with key {8{32'h00112233}} (256-bit field), nonce {3{32'h01020304}}, one block {16{32'hdeadbeef}} last=1, bus model ready immediately:
  - Writes occur in order 10, 20, 08=1, 30, 08=2, 08=4 with zero-extended values.
  - out_data matches model result; tag_valid with tag_err=0.
- Three-block job with out_ready stalled 5 cycles per block: exactly 3 out beats, out_last only on the third, no bus strobes while stalled.
- Status ready bit delayed 10 polls: T+6 accept shifts by 20 cycles; poll reads alternate strobe/idle.
- Status never set, POLL_LIMIT=4: after 4 samples, tag_valid=1, tag_err=1, tag=0, then IDLE.
- Reset pulsed during WR_NEXT wait: cs drops in the same cycle, job_ready=1 after release, a fresh job completes correctly.

Source files
------------

// File: rtl/aead_bus_pkg.sv
// Shared constants for the AEAD bus sequencer: default register map, control words,
// status bit positions and FSM state encodings.
package aead_bus_pkg;

  // Default register map of the ChaCha20-Poly1305 register block.
  localparam logic [7:0] REG_CTRL   = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h09;
  localparam logic [7:0] REG_KEY    = 8'h10;
  localparam logic [7:0] REG_NONCE  = 8'h20;
  localparam logic [7:0] REG_DATA   = 8'h30;
  localparam logic [7:0] REG_RESULT = 8'h40;
  localparam logic [7:0] REG_TAG    = 8'h50;

  // Control words written to REG_CTRL.
  localparam logic [511:0] CTRL_INIT = 512'h1;
  localparam logic [511:0] CTRL_NEXT = 512'h2;
  localparam logic [511:0] CTRL_DONE = 512'h4;

  // Status register bit positions.
  localparam int unsigned STATUS_RDY_BIT = 0;
  localparam int unsigned STATUS_VAL_BIT = 1;

  // FSM state encodings.
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_WR_KEY    = 4'd1;
  localparam state_t ST_WR_NONCE  = 4'd2;
  localparam state_t ST_WR_INIT   = 4'd3;
  localparam state_t ST_POLL_RDY  = 4'd4;
  localparam state_t ST_WAIT_BLK  = 4'd5;
  localparam state_t ST_WR_DATA   = 4'd6;
  localparam state_t ST_WR_NEXT   = 4'd7;
  localparam state_t ST_POLL_VAL  = 4'd8;
  localparam state_t ST_RD_RES    = 4'd9;
  localparam state_t ST_OUT       = 4'd10;
  localparam state_t ST_WR_DONE   = 4'd11;
  localparam state_t ST_POLL_RDY2 = 4'd12;
  localparam state_t ST_RD_TAG    = 4'd13;
  localparam state_t ST_TAG       = 4'd14;

endpackage

// File: rtl/aead_bus_sequencer_poll_counter.sv
// Counts unsuccessful status samples within one poll wait.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   clr_i  - clear the count (entry to a poll state)
//   inc_i  - one more unsuccessful sample
//   term_o - the current count is LIMIT-1: one more failed sample ends the wait
module poll_counter #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/aead_bus_sequencer.sv
// Bus master that runs one ChaCha20-Poly1305 AEAD job against the register block:
// writes key/nonce/init, then per block writes data + next, polls for the result and
// reads it back, and finally issues done and reads the tag.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   job_*                       - job handshake carrying key and nonce
//   blk_*                       - input data blocks, blk_last marks the final one
//   out_*                       - processed blocks returned to the consumer
//   tag_*, tag, tag_err         - final tag, tag_err=1 on poll timeout (tag=0)
//   cs, we, address, write_data - register bus master outputs
//   read_data                   - register bus read data, valid the cycle after a read
module aead_bus_sequencer
  import aead_bus_pkg::*;
#(
  parameter int unsigned POLL_LIMIT  = 64,
  parameter logic [7:0]  ADDR_CTRL   = REG_CTRL,
  parameter logic [7:0]  ADDR_STATUS = REG_STATUS,
  parameter logic [7:0]  ADDR_KEY    = REG_KEY,
  parameter logic [7:0]  ADDR_NONCE  = REG_NONCE,
  parameter logic [7:0]  ADDR_DATA   = REG_DATA,
  parameter logic [7:0]  ADDR_RESULT = REG_RESULT,
  parameter logic [7:0]  ADDR_TAG    = REG_TAG
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_key,
  input  logic [95:0]  job_nonce,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         out_last,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic [127:0] tag,
  output logic         tag_err,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [511:0] write_data,
  input  logic [511:0] read_data
);

  state_t         state_q, state_d;
  // Read states have two phases: 0 strobes the read, 1 samples read_data.
  logic           phase_q, phase_d;
  logic [255:0]   key_q, key_d;
  logic [95:0]    nonce_q, nonce_d;
  logic [511:0]   blk_q, blk_d;
  logic           last_q, last_d;
  logic [511:0]   out_data_q, out_data_d;
  logic [127:0]   tag_q, tag_d;
  logic           tag_err_q, tag_err_d;

  logic           poll_clr, poll_inc, poll_term;
  logic           poll_hit;
  state_t         poll_next;

  poll_counter #(
    .LIMIT (POLL_LIMIT)
  ) u_poll_counter (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (poll_clr),
    .inc_i  (poll_inc),
    .term_o (poll_term)
  );

  // Which status bit the current poll waits on, and where a successful poll goes.
  always_comb begin
    poll_hit  = read_data[STATUS_RDY_BIT];
    poll_next = ST_WAIT_BLK;
    case (state_q)
      ST_POLL_VAL: begin
        poll_hit  = read_data[STATUS_VAL_BIT];
        poll_next = ST_RD_RES;
      end
      ST_POLL_RDY2: poll_next = ST_RD_TAG;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    blk_d      = blk_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    tag_d      = tag_q;
    tag_err_d  = tag_err_q;
    poll_clr   = 1'b0;
    poll_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          key_d   = job_key;
          nonce_d = job_nonce;
          state_d = ST_WR_KEY;
        end
      end
      ST_WR_KEY:   state_d = ST_WR_NONCE;
      ST_WR_NONCE: state_d = ST_WR_INIT;
      ST_WR_INIT: begin
        poll_clr = 1'b1;
        phase_d  = 1'b0;
        state_d  = ST_POLL_RDY;
      end
      ST_POLL_RDY, ST_POLL_VAL, ST_POLL_RDY2: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (poll_hit) begin
            state_d = poll_next;
          end else if (poll_term) begin
            tag_d     = '0;
            tag_err_d = 1'b1;
            state_d   = ST_TAG;
          end else begin
            poll_inc = 1'b1;
          end
        end
      end
      ST_WAIT_BLK: begin
        if (blk_valid) begin
          blk_d   = blk_data;
          last_d  = blk_last;
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: state_d = ST_WR_NEXT;
      ST_WR_NEXT: begin
        poll_clr = 1'b1;
        phase_d  = 1'b0;
        state_d  = ST_POLL_VAL;
      end
      ST_RD_RES: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          out_data_d = read_data;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = last_q ? ST_WR_DONE : ST_WAIT_BLK;
        end
      end
      ST_WR_DONE: begin
        poll_clr = 1'b1;
        phase_d  = 1'b0;
        state_d  = ST_POLL_RDY2;
      end
      ST_RD_TAG: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d   = 1'b0;
          tag_d     = read_data[127:0];
          tag_err_d = 1'b0;
          state_d   = ST_TAG;
        end
      end
      ST_TAG: begin
        if (tag_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        phase_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      key_q      <= '0;
      nonce_q    <= '0;
      blk_q      <= '0;
      last_q     <= 1'b0;
      out_data_q <= '0;
      tag_q      <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      blk_q      <= blk_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      tag_q      <= tag_d;
      tag_err_q  <= tag_err_d;
    end
  end

  // Bus outputs decode state only, so reset drops them asynchronously and no
  // ready input can reach them combinationally.
  always_comb begin
    cs         = 1'b0;
    we         = 1'b0;
    address    = '0;
    write_data = '0;
    case (state_q)
      ST_WR_KEY: begin
        cs = 1'b1; we = 1'b1; address = ADDR_KEY;   write_data = {256'h0, key_q};
      end
      ST_WR_NONCE: begin
        cs = 1'b1; we = 1'b1; address = ADDR_NONCE; write_data = {416'h0, nonce_q};
      end
      ST_WR_INIT: begin
        cs = 1'b1; we = 1'b1; address = ADDR_CTRL;  write_data = CTRL_INIT;
      end
      ST_WR_DATA: begin
        cs = 1'b1; we = 1'b1; address = ADDR_DATA;  write_data = blk_q;
      end
      ST_WR_NEXT: begin
        cs = 1'b1; we = 1'b1; address = ADDR_CTRL;  write_data = CTRL_NEXT;
      end
      ST_WR_DONE: begin
        cs = 1'b1; we = 1'b1; address = ADDR_CTRL;  write_data = CTRL_DONE;
      end
      ST_POLL_RDY, ST_POLL_VAL, ST_POLL_RDY2: begin
        cs = !phase_q; address = phase_q ? 8'h00 : ADDR_STATUS;
      end
      ST_RD_RES: begin
        cs = !phase_q; address = phase_q ? 8'h00 : ADDR_RESULT;
      end
      ST_RD_TAG: begin
        cs = !phase_q; address = phase_q ? 8'h00 : ADDR_TAG;
      end
      default: ;
    endcase
  end

  assign job_ready = (state_q == ST_IDLE);
  assign blk_ready = (state_q == ST_WAIT_BLK);
  assign out_valid = (state_q == ST_OUT);
  assign tag_valid = (state_q == ST_TAG);
  assign out_data  = out_data_q;
  assign out_last  = last_q;
  assign tag       = tag_q;
  assign tag_err   = tag_err_q;

endmodule
